nlc_sequencer: RTL and testbench

NLC_SEQUENCER -- requirements
Module: nlc_sequencer

---
 rtl/nlc_sequencer.sv | 115 +++++++++++
 tb/tb_nlc_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nlc_sequencer.sv
// Handshake sequencer in front of a non-linearity corrector: accepts one sample,
// strobes it into the NLC, waits (bounded) for the result and holds it downstream.
module nlc_sequencer #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [20:0] s_x_adc_i,
    input  logic [1:0]  s_mode_i,
    input  logic [20:0] s_x_ref_i,
    output logic        srdyi_o,
    output logic [20:0] x_adc_o,
    output logic [1:0]  operation_mode_o,
    output logic [20:0] x_ref_o,
    input  logic        srdyo_i,
    input  logic [20:0] x_lin_i,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [20:0] m_x_lin_o,
    output logic        err_timeout_o,
    output logic [15:0] sample_cnt_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

    state_t      state_reg;
    logic [9:0]  wait_cnt_reg;
    logic [9:0]  wait_cnt_next;
    logic        s_ready_reg;
    logic        srdyi_reg;
    logic [20:0] x_adc_reg;
    logic [1:0]  mode_reg;
    logic [20:0] x_ref_reg;
    logic        m_valid_reg;
    logic [20:0] m_x_lin_reg;
    logic        err_reg;
    logic [15:0] sample_cnt_reg;

    // Counter value after the current WAIT cycle; the timeout fires on the cycle it reaches TIMEOUT.
    assign wait_cnt_next = wait_cnt_reg + 10'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= '0;
            s_ready_reg    <= 1'b0;
            srdyi_reg      <= 1'b0;
            x_adc_reg      <= '0;
            mode_reg       <= '0;
            x_ref_reg      <= '0;
            m_valid_reg    <= 1'b0;
            m_x_lin_reg    <= '0;
            err_reg        <= 1'b0;
            sample_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (s_valid_i && s_ready_reg) begin
                        x_adc_reg   <= s_x_adc_i;
                        mode_reg    <= s_mode_i;
                        x_ref_reg   <= s_x_ref_i;
                        srdyi_reg   <= 1'b1;
                        s_ready_reg <= 1'b0;
                        state_reg   <= ISSUE;
                    end else begin
                        s_ready_reg <= 1'b1;
                    end
                end
                ISSUE: begin
                    srdyi_reg    <= 1'b0;
                    wait_cnt_reg <= '0;
                    state_reg    <= WAIT;
                end
                WAIT: begin
                    wait_cnt_reg <= wait_cnt_next;
                    // A response on the final counted cycle still beats the timeout.
                    if (srdyo_i) begin
                        m_x_lin_reg <= x_lin_i;
                        m_valid_reg <= 1'b1;
                        state_reg   <= HOLD;
                    end else if (wait_cnt_next == TIMEOUT_CNT) begin
                        err_reg     <= 1'b1;
                        m_x_lin_reg <= '0;
                        m_valid_reg <= 1'b1;
                        state_reg   <= HOLD;
                    end
                end
                HOLD: begin
                    if (m_ready_i) begin
                        m_valid_reg    <= 1'b0;
                        sample_cnt_reg <= sample_cnt_reg + 16'd1;
                        s_ready_reg    <= 1'b1;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign s_ready_o        = s_ready_reg;
    assign srdyi_o          = srdyi_reg;
    assign x_adc_o          = x_adc_reg;
    assign operation_mode_o = mode_reg;
    assign x_ref_o          = x_ref_reg;
    assign m_valid_o        = m_valid_reg;
    assign m_x_lin_o        = m_x_lin_reg;
    assign err_timeout_o    = err_reg;
    assign sample_cnt_o     = sample_cnt_reg;

endmodule

// File: tb/tb_nlc_sequencer.sv
// Randomized bench for nlc_sequencer: each transaction's outcome (capture vs timeout,
// result latency, result value, counters) is predicted from the response delay alone.
module tb_nlc_sequencer;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [20:0] s_x_adc_i = '0;
    logic [1:0]  s_mode_i = '0;
    logic [20:0] s_x_ref_i = '0;
    logic        srdyi_o;
    logic [20:0] x_adc_o;
    logic [1:0]  operation_mode_o;
    logic [20:0] x_ref_o;
    logic        srdyo_i = 1'b0;
    logic [20:0] x_lin_i = '0;
    logic        m_valid_o;
    logic        m_ready_i = 1'b0;
    logic [20:0] m_x_lin_o;
    logic        err_timeout_o;
    logic [15:0] sample_cnt_o;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [15:0] exp_cnt = '0;
    logic        exp_err = 1'b0;

    nlc_sequencer #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .s_x_adc_i(s_x_adc_i), .s_mode_i(s_mode_i), .s_x_ref_i(s_x_ref_i),
        .srdyi_o(srdyi_o), .x_adc_o(x_adc_o), .operation_mode_o(operation_mode_o),
        .x_ref_o(x_ref_o), .srdyo_i(srdyo_i), .x_lin_i(x_lin_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_x_lin_o(m_x_lin_o),
        .err_timeout_o(err_timeout_o), .sample_cnt_o(sample_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One full transaction. d = cycles from the srdyi pulse to the single srdyo pulse
    // (0 lands in ISSUE and is ignored); h = backpressure cycles before m_ready.
    task automatic run_txn(input logic [20:0] adc, input logic [1:0] mode,
                           input logic [20:0] xref, input int d, input int h,
                           input bit pressure, input logic [20:0] lin);
        bit          cap;
        int          lat;
        int          w;
        logic [20:0] exp_data;
        cap = (d >= 1) && (d <= T);
        lat = cap ? d : T;
        exp_data = cap ? lin : 21'd0;
        s_x_adc_i = adc; s_mode_i = mode; s_x_ref_i = xref; s_valid_i = 1'b1;
        srdyo_i = pressure;
        w = 0;
        while (!s_ready_o && w < 20) begin tick(); w++; end
        n_vec++;
        if (s_ready_o !== 1'b1) begin
            n_err++; $display("FAIL ready_wait s_ready_o=%b required 1", s_ready_o);
        end
        tick();
        acc_cyc = cyc;
        s_valid_i = pressure;
        s_x_adc_i = ~adc;
        s_x_ref_i = ~xref;
        n_vec++;
        if ({srdyi_o, x_adc_o, operation_mode_o, x_ref_o, s_ready_o, m_valid_o} !==
            {1'b1, adc, mode, xref, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL issue srdyi=%b adc=%h mode=%b ref=%h rdy=%b mv=%b required 1 %h %b %h 0 0",
                     srdyi_o, x_adc_o, operation_mode_o, x_ref_o, s_ready_o, m_valid_o, adc, mode, xref);
        end
        srdyo_i = (d == 0);
        x_lin_i = (d == 0) ? lin : ~lin;
        for (int j = 1; j <= lat; j++) begin
            tick();
            n_vec++;
            if ({srdyi_o, m_valid_o, x_adc_o} !== {1'b0, 1'b0, adc}) begin
                n_err++;
                $display("FAIL wait j=%0d srdyi=%b mv=%b adc=%h required 0 0 %h", j, srdyi_o, m_valid_o, x_adc_o, adc);
            end
            srdyo_i = (j == d);
            x_lin_i = (j == d) ? lin : ~lin;
        end
        tick();
        srdyo_i = 1'b0;
        if (!cap) exp_err = 1'b1;
        n_vec++;
        if ({m_valid_o, m_x_lin_o, err_timeout_o} !== {1'b1, exp_data, exp_err}) begin
            n_err++;
            $display("FAIL result d=%0d mv=%b data=%h err=%b required 1 %h %b",
                     d, m_valid_o, m_x_lin_o, err_timeout_o, exp_data, exp_err);
        end
        for (int k = 0; k < h; k++) begin
            srdyo_i = pressure ? 1'($urandom_range(0, 1)) : 1'b0;
            x_lin_i = 21'($urandom);
            tick();
            n_vec++;
            if ({m_valid_o, m_x_lin_o, s_ready_o, x_adc_o, x_ref_o} !== {1'b1, exp_data, 1'b0, adc, xref}) begin
                n_err++;
                $display("FAIL hold k=%0d mv=%b data=%h rdy=%b adc=%h ref=%h required 1 %h 0 %h %h",
                         k, m_valid_o, m_x_lin_o, s_ready_o, x_adc_o, x_ref_o, exp_data, adc, xref);
            end
        end
        srdyo_i = 1'b0;
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
        s_valid_i = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        n_vec++;
        if ({m_valid_o, s_ready_o, sample_cnt_o, err_timeout_o} !== {1'b0, 1'b1, exp_cnt, exp_err}) begin
            n_err++;
            $display("FAIL release mv=%b rdy=%b cnt=%0d err=%b required 0 1 %0d %b",
                     m_valid_o, s_ready_o, sample_cnt_o, err_timeout_o, exp_cnt, exp_err);
        end
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        if ({s_ready_o, srdyi_o, m_valid_o, err_timeout_o, m_x_lin_o, x_adc_o, x_ref_o,
             operation_mode_o, sample_cnt_o} !== '0) begin
            n_err++;
            $display("FAIL %s rdy=%b srdyi=%b mv=%b err=%b lin=%h adc=%h ref=%h mode=%b cnt=%0d required all 0",
                     tag, s_ready_o, srdyi_o, m_valid_o, err_timeout_o, m_x_lin_o, x_adc_o, x_ref_o,
                     operation_mode_o, sample_cnt_o);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        check_zero("reset_hold");
        reset = 1'b1;
        exp_cnt = '0; exp_err = 1'b0;
        n_vec++;
        if (s_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_release_early rdy=%b required 0", s_ready_o); end
        tick();
        n_vec++;
        if (s_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_release rdy=%b required 1", s_ready_o); end
        $display("reset: released, counters cleared");
    endtask

    task automatic test_single();
        run_txn(21'h00ABC, 2'b11, 21'h01234, 3, 4, 1'b0, 21'h1F000);
        $display("single: adc=00abc mode=3 lin=1f000 cnt=%0d", sample_cnt_o);
    endtask

    task automatic test_backpressure();
        run_txn(21'h15555, 2'b01, 21'h0AAAA, 2, 10, 1'b1, 21'h0BEEF);
        $display("backpressure: 10 cycles held, second sample refused");
    endtask

    task automatic test_boundary();
        run_txn(21'h00001, 2'b10, 21'h1FFFF, T, 1, 1'b1, 21'h12345);
        $display("boundary: srdyo on cycle %0d captured, err=%b", T, err_timeout_o);
    endtask

    task automatic test_timeout();
        run_txn(21'h0F0F0, 2'b00, 21'h00F0F, T + 3, 2, 1'b0, 21'h1AAAA);
        run_txn(21'h00777, 2'b01, 21'h00555, 0, 0, 1'b0, 21'h1CCCC);
        run_txn(21'h00042, 2'b10, 21'h00024, 5, 1, 1'b0, 21'h0D00D);
        $display("timeout: err sticky=%b, recovery result=%h", err_timeout_o, m_x_lin_o);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_txn(21'($urandom), 2'($urandom), 21'($urandom), int'($urandom_range(0, T + 2)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 21'($urandom));
            $display("random %0d: result=%h err=%b cnt=%0d", i, m_x_lin_o, err_timeout_o, sample_cnt_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        s_x_adc_i = 21'h1357A; s_mode_i = 2'b11; s_x_ref_i = 21'h02468; s_valid_i = 1'b1;
        for (int w = 0; w < 20 && !s_ready_o; w++) tick();
        tick();
        s_valid_i = 1'b0;
        tick(); tick();
        #2 reset = 1'b0;
        #1 check_zero("reset_async");
        tick();
        check_zero("reset_mid_wait");
        reset = 1'b1;
        exp_cnt = '0; exp_err = 1'b0;
        tick();
        n_vec++;
        if ({s_ready_o, m_valid_o, sample_cnt_o} !== {1'b1, 1'b0, 16'd0}) begin
            n_err++;
            $display("FAIL restart rdy=%b mv=%b cnt=%0d required 1 0 0", s_ready_o, m_valid_o, sample_cnt_o);
        end
        $display("reset mid-wait: restart clean");
    endtask

    task automatic test_back_to_back();
        int prev;
        run_txn(21'($urandom), 2'($urandom), 21'($urandom), 1, 0, 1'b0, 21'($urandom));
        prev = acc_cyc;
        for (int i = 0; i < 200; i++) begin
            run_txn(21'($urandom), 2'($urandom), 21'($urandom), 1, 0, 1'b0, 21'($urandom));
            n_vec++;
            if (acc_cyc - prev !== 4) begin
                n_err++; $display("FAIL spacing i=%0d got %0d cycles required 4", i, acc_cyc - prev);
            end
            prev = acc_cyc;
        end
        $display("back_to_back: 201 samples, cnt=%0d", sample_cnt_o);
    endtask

    initial begin
        x_lin_i = 21'($urandom);
        #1;
        test_reset();
        test_single();
        test_backpressure();
        test_boundary();
        test_timeout();
        test_random();
        test_reset_mid_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
